cdc_2phase_src: RTL and testbench



---
 rtl/cdc_2phase_pkg.sv | 19 +
 rtl/sync_sr.sv | 25 ++
 rtl/cdc_2phase_src.sv | 87 ++++++++
 tb/tb_cdc_2phase_src.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_2phase_pkg.sv
// rtl/cdc_2phase_pkg.sv - shared types and toggle-protocol constants for the two-phase CDC pair
package cdc_2phase_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } cdc_state_e;

    // Both ends of the handshake start from the same toggle level after reset.
    localparam logic REQ_RESET = 1'b0;
    localparam logic ACK_RESET = 1'b0;

    function automatic int cnt_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_sr.sv
// rtl/sync_sr.sv - multi-flop synchronizer chain with synchronous active-high reset
module sync_sr
    import cdc_2phase_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_chain <= {STAGES{ACK_RESET}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_chain[STAGES-1];

endmodule

// File: rtl/cdc_2phase_src.sv
// rtl/cdc_2phase_src.sv - source half of a two-phase toggle CDC handshake
module cdc_2phase_src
    import cdc_2phase_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  async_req_o,
    output logic [DATA_WIDTH-1:0] async_data_o,
    input  logic                  async_ack_i,
    output logic                  busy_o,
    output logic                  timeout_o
);

    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    cdc_state_e            r_state;
    logic                  r_req;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CW-1:0]         r_cnt;
    logic                  r_to;
    logic                  w_ack_sync;
    logic                  w_ack_match;
    logic                  w_ready;

    sync_sr #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (async_ack_i),
        .q_o  (w_ack_sync)
    );

    // A stale ack level after a one-sided reset keeps ready low until it drains.
    assign w_ack_match = (w_ack_sync == r_req);
    assign w_ready     = (r_state == IDLE) && w_ack_match;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_req   <= REQ_RESET;
            r_data  <= '0;
            r_cnt   <= '0;
            r_to    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i && w_ready) begin
                        r_data  <= data_i;
                        r_req   <= ~r_req;
                        r_cnt   <= '0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_ack_match) begin
                        r_state <= IDLE;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                        if (r_cnt == CNT_LAST) begin
                            r_to <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o      = w_ready;
    assign busy_o       = (r_state == WAIT);
    assign async_req_o  = r_req;
    assign async_data_o = r_data;
    assign timeout_o    = r_to;

endmodule

// File: tb/tb_cdc_2phase_src.sv
// tb/tb_cdc_2phase_src.sv - scoreboard bench for cdc_2phase_src with a modelled remote acknowledger
module tb_cdc_2phase_src;

    localparam int DW  = 32;
    localparam int SS  = 2;
    localparam int TO  = 8;
    localparam int INF = 1 << 30;

    typedef struct {
        logic [DW-1:0] data;
        logic          req;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          ready;
    logic [DW-1:0] din;
    logic          req;
    logic [DW-1:0] dout;
    logic          ack;
    logic          busy;
    logic          tmo;

    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    m_acc       = INF;
    int    m_done      = INF;
    logic  m_req       = 1'b0;
    bit    m_to        = 1'b0;
    logic  last_req    = 1'b0;
    bit    mon_en      = 1'b0;
    bit    auto_ack    = 1'b0;
    int    ack_delay   = 0;
    int    r_dly       = 0;
    xfer_t exp_q[$];
    xfer_t cur;

    cdc_2phase_src #(
        .DATA_WIDTH    (DW),
        .SYNC_STAGES   (SS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid),
        .ready_o     (ready),
        .data_i      (din),
        .async_req_o (req),
        .async_data_o(dout),
        .async_ack_i (ack),
        .busy_o      (busy),
        .timeout_o   (tmo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer in flight after edge c: accepted at or before c, ack not yet seen through the synchronizer.
    function automatic bit busy_m(input int c);
        return (m_acc <= c) && (c < m_done);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_req    = 1'b0;
        m_acc    = INF;
        m_done   = INF;
        m_to     = 1'b0;
        last_req = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] w, input bit drop);
        int budget;
        bit done;
        budget = 0;
        done   = 1'b0;
        valid  = 1'b1;
        din    = w;
        while (!done) begin
            @(negedge clk);
            if (!busy_m(cyc)) begin
                exp_q.push_back('{data: w, req: ~m_req});
                m_req  = ~m_req;
                m_acc  = cyc + 1;
                m_done = INF;
                done   = 1'b1;
            end else if (++budget > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: word %0h never accepted", w);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (drop) valid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (busy_m(cyc) && budget < 300);
        if (budget >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: transfer never completed");
        end
        @(posedge clk);
        #1;
    endtask

    // Remote destination: answers each request toggle after ack_delay cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack && !rst && (req !== ack)) begin
                if (r_dly >= ack_delay) begin
                    ack    = req;
                    m_done = cyc + 1 + SS;
                    r_dly  = 0;
                end else begin
                    r_dly++;
                end
            end else begin
                r_dly = 0;
            end
        end
    end

    // Monitor: per-cycle handshake flags plus scoreboard pop on every request toggle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (m_acc != INF && cyc >= m_acc + TO && m_done > m_acc + TO) m_to = 1'b1;
                check("ready", DW'(ready), DW'(!busy_m(cyc)));
                check("busy", DW'(busy), DW'(busy_m(cyc)));
                check("timeout", DW'(tmo), DW'(m_to));
                if (req !== last_req) begin
                    last_req = req;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_req: toggle to %0b with no word pending", req);
                    end else begin
                        cur = exp_q.pop_front();
                        check("req_level", DW'(req), DW'(cur.req));
                        check("data", dout, cur.data);
                    end
                end else if (busy_m(cyc)) begin
                    check("data_stable", dout, cur.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        rst   = 1'b1;
        valid = 1'b0;
        din   = '0;
        ack   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_ready", DW'(ready), DW'(1));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_req", DW'(req), DW'(0));
        check("rst_data", dout, '0);
        check("rst_timeout", DW'(tmo), DW'(0));
        rst = 1'b0;
        model_clear();
        mon_en   = 1'b1;
        auto_ack = 1'b1;
        @(posedge clk);
        #1;

        // Delay 5 makes the ack match land on the same edge as the timeout threshold.
        ack_delay = 5;
        send(32'hDEADBEEF, 1'b1);
        wait_idle();

        ack_delay = 2;
        send(32'h1, 1'b0);
        send(32'h2, 1'b0);
        send(32'h3, 1'b1);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            ack_delay = $urandom_range(0, 5);
            send($urandom, 1'b1);
            gap = $urandom_range(0, 3);
            for (int j = 0; j < gap; j++) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();

        ack_delay = 20;
        send(32'h0BADF00D, 1'b1);
        wait_idle();
        check("timeout_sticky", DW'(tmo), DW'(1));

        // Reset in the middle of a withheld transfer, remote ack left high.
        mon_en   = 1'b0;
        auto_ack = 1'b0;
        rst      = 1'b1;
        ack      = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_clear();
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        send(32'hCAFEF00D, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst    = 1'b1;
        ack    = 1'b1;
        @(posedge clk);
        #2;
        check("midrst_busy", DW'(busy), DW'(0));
        check("midrst_req", DW'(req), DW'(0));
        check("midrst_data", dout, '0);
        check("midrst_timeout", DW'(tmo), DW'(0));
        check("midrst_ready", DW'(ready), DW'(1));
        rst = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            check("stale_ack_ready", DW'(ready), DW'(0));
            check("stale_ack_busy", DW'(busy), DW'(0));
            check("stale_ack_req", DW'(req), DW'(0));
        end
        ack = 1'b0;
        @(posedge clk);
        #2;
        check("ack_drain_ready0", DW'(ready), DW'(0));
        @(posedge clk);
        #2;
        check("ack_drain_ready1", DW'(ready), DW'(1));

        model_clear();
        mon_en    = 1'b1;
        auto_ack  = 1'b1;
        ack_delay = 3;
        @(posedge clk);
        #1;
        send(32'h12345678, 1'b1);
        wait_idle();
        check("scoreboard_empty", DW'(exp_q.size()), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
